// File: rtl/if_stage_pkg.sv
// Shared widths, reset/bubble constants, FSM encodings and the fetch-output
// payload for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ILEN       = 32;
    localparam int unsigned IF_IMEM_AW = 14;

    localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h1000_0000;
    localparam logic [ILEN-1:0] IF_NOP_INST  = 32'h0000_0013;

    localparam logic [1:0] IF_BOOT = 2'd0;
    localparam logic [1:0] IF_RUN  = 2'd1;
    localparam logic [1:0] IF_HOLD = 2'd2;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_out_t;

endpackage

// File: rtl/if_skid_buf.sv
// Hold register for the inst/pc/valid presented to decode while fetch is stalled.
// Capture loads a new payload; release kills the held valid bit.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_capture,
    input  logic    i_release,
    input  if_out_t i_din,
    output if_out_t o_dout
);

    if_out_t r_skid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid <= '0;
        end else if (i_capture) begin
            r_skid <= i_din;
        end else if (i_release) begin
            r_skid.valid <= 1'b0;
        end
    end

    assign o_dout = r_skid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the word PC, drives a 1-cycle-latency imem and
// handles stall hold, redirect and bubbles. Optional IF_PERF_CNT_EN adds counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
    parameter int unsigned     IMEM_AW  = IF_IMEM_AW,
    parameter logic [ILEN-1:0] NOP_INST = IF_NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_addr_i,
    output logic               imem_en_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [ILEN-1:0]    imem_dout_i,
    output logic [ILEN-1:0]    inst_o,
    output logic [XLEN-1:0]    pc_o,
    output logic               valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_bubble_o
`endif
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_req_pc;
    logic            r_drop_q;
    logic            r_pend_v;
    logic [XLEN-1:0] r_pend_addr;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_req_pc_nxt;
    logic            w_drop_nxt;
    logic            w_pend_v_nxt;
    logic [XLEN-1:0] w_pend_addr_nxt;
    logic            w_en;
    logic [XLEN-1:0] w_fetch_addr;
    logic            w_capture;
    logic            w_release;
    if_out_t         w_out;
    if_out_t         w_skid;

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_release (w_release),
        .i_din     (w_out),
        .o_dout    (w_skid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IF_BOOT;
            r_req_pc    <= RESET_PC;
            r_drop_q    <= 1'b1;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_drop_q    <= w_drop_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    // Next-fetch mux and FSM; a drop cycle re-fetches req_pc so the target is not skipped
    always_comb begin
        w_state_nxt     = r_state;
        w_req_pc_nxt    = r_req_pc;
        w_drop_nxt      = r_drop_q;
        w_pend_v_nxt    = r_pend_v;
        w_pend_addr_nxt = r_pend_addr;
        w_en            = 1'b0;
        w_fetch_addr    = r_req_pc;
        w_capture       = 1'b0;
        w_release       = 1'b0;
        w_out.inst      = NOP_INST;
        w_out.pc        = r_req_pc;
        w_out.valid     = 1'b0;

        case (r_state)
            IF_BOOT: begin
                w_en        = 1'b1;
                w_drop_nxt  = 1'b0;
                w_state_nxt = IF_RUN;
            end
            IF_RUN: begin
                w_out.inst  = r_drop_q ? NOP_INST : imem_dout_i;
                w_out.pc    = r_req_pc;
                w_out.valid = !r_drop_q;
                if (stall_i) begin
                    w_capture   = 1'b1;
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = IF_HOLD;
                    if (redirect_i) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_addr_nxt = redirect_addr_i;
                    end
                end else begin
                    w_en         = 1'b1;
                    w_fetch_addr = redirect_i ? redirect_addr_i
                                 : (r_drop_q ? r_req_pc : r_req_pc + 32'd1);
                    w_req_pc_nxt = w_fetch_addr;
                    w_drop_nxt   = redirect_i;
                end
            end
            IF_HOLD: begin
                w_out = w_skid;
                if (stall_i) begin
                    if (redirect_i) begin
                        w_pend_v_nxt    = 1'b1;
                        w_pend_addr_nxt = redirect_addr_i;
                    end
                end else begin
                    w_release    = 1'b1;
                    w_en         = 1'b1;
                    w_out.valid  = w_skid.valid && !r_pend_v;
                    if (redirect_i) begin
                        w_fetch_addr = redirect_addr_i;
                    end else if (r_pend_v) begin
                        w_fetch_addr = r_pend_addr;
                    end else begin
                        w_fetch_addr = w_skid.valid ? r_req_pc + 32'd1 : r_req_pc;
                    end
                    w_req_pc_nxt = w_fetch_addr;
                    w_drop_nxt   = redirect_i;
                    w_pend_v_nxt = 1'b0;
                    w_state_nxt  = IF_RUN;
                end
            end
            default: begin
                w_state_nxt = IF_BOOT;
            end
        endcase
    end

    assign imem_en_o   = w_en;
    assign imem_addr_o = w_fetch_addr[IMEM_AW-1:0];
    assign inst_o      = w_out.inst;
    assign pc_o        = w_out.pc;
    assign valid_o     = w_out.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    // Only cycles where decode advances are counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else if (!stall_i) begin
            if (w_out.valid) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end else begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetch_o  = r_perf_fetch;
    assign perf_bubble_o = r_perf_bubble;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. Owns the word-addressed PC. Drives a synchronous-read instruction memory with 1-cycle read latency. Presents instruction/PC/valid to decode combinationally. Handles stall hold, branch/jump redirect, and bubble insertion.

Parameters:
RESET_PC, 32'h1000_0000, word address fetched first after reset
IMEM_AW, 14, instruction memory word-address width
NOP_INST, 32'h0000_0013, instruction presented on bubbles (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold fetch; decode must see identical inst/pc next cycle
redirect_i  in  1  taken branch/jump resolved in decode this cycle
redirect_addr_i  in  32  redirect target, word address
imem_en_o  out  1  memory read enable
imem_addr_o  out  IMEM_AW  memory read address, low bits of next-fetch PC
imem_dout_i  in  32  memory data for the address issued last cycle
inst_o  out  32  instruction to decode
pc_o  out  32  word address of inst_o
valid_o  out  1  inst_o is architecturally live

Behaviour:
- Address register req_pc holds the address issued last cycle; imem_dout_i corresponds to req_pc.
- States: BOOT, RUN, HOLD.
- Reset: state=BOOT; req_pc=RESET_PC; skid cleared; pending_redirect=0; drop_q=1.
- Reset outputs: inst_o=NOP_INST, valid_o=0, pc_o=RESET_PC, imem_en_o=1, imem_addr_o=RESET_PC[IMEM_AW-1:0].
- BOOT, one cycle: issue RESET_PC, output a bubble, go to RUN.
- RUN:
  - inst_o=imem_dout_i, pc_o=req_pc, valid_o=!drop_q.
  - Next address = redirect_addr_i if redirect_i, else req_pc+1; req_pc updated to it.
  - Wraps modulo 2^32 at 32'hFFFF_FFFF.
- Redirect: the instruction returning next cycle is from the wrong path. Set drop_q=1 so next cycle shows inst_o=NOP_INST, valid_o=0. Net penalty is 1 bubble.
- stall_i in RUN:
  - Capture current inst/pc/valid into skid; go to HOLD.
  - imem_en_o=0; req_pc unchanged.
  - Outputs in the stall cycle are the same as in RUN.
- HOLD:
  - Outputs come from skid; imem_en_o=0.
  - On stall_i deassert: re-issue req_pc+1, or the pending target; return to RUN.
  - Outputs for that cycle still come from skid.
- Redirect during HOLD (or with stall_i in RUN): latch redirect_addr_i into pending_redirect.
  - Last redirect wins.
  - Applied on the first non-stall cycle; skid valid is cleared at that point.
- drop_q clears after one RUN cycle. No instruction is ever presented twice with valid_o=1 once decode has advanced.
- rst mid-stall or mid-redirect: everything returns to the reset state in one cycle; pending redirect is discarded.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs perf_fetch_o[31:0] and perf_bubble_o[31:0].
  - perf_fetch_o counts cycles with valid_o=1 && !stall_i.
  - perf_bubble_o counts cycles with valid_o=0 && !stall_i.
  - Both reset to 0 and wrap silently.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared defines package: NOP_INST, RESET_PC, state encodings IF_BOOT=2'd0, IF_RUN=2'd1, IF_HOLD=2'd2, and the existing word/register bus widths.
- One sub-module: if_skid_buf, holding the inst/pc/valid hold register with capture/release controls.
- Next-PC mux and FSM stay in if_stage.

Test Plan:
- Reset release, no stall: imem_addr_o steps 10000000, 10000001, 10000002. valid_o=0 in the BOOT cycle, then valid_o=1 with pc_o=10000000, 10000001 on consecutive cycles.
- Redirect to 10000040 while pc_o=10000003:
  - next cycle inst_o=00000013, valid_o=0;
  - following cycle pc_o=10000040, valid_o=1.
- stall_i high 3 cycles at pc_o=10000005: inst_o/pc_o constant for 4 cycles, imem_en_o=0 during HOLD. After release, pc_o=10000006 with no duplicate valid.
- Redirect to 10000080 asserted mid-stall, then stall released: 1 bubble, then pc_o=10000080. The fall-through 10000006 never appears valid.
- rst asserted during HOLD with a pending redirect: next cycle matches the reset values; first valid pc_o=10000000.
- req_pc=FFFFFFFF, no stall: next imem_addr_o=0 and pc_o=00000000 follows. With IF_PERF_CNT_EN, perf_bubble_o increments exactly once per redirect.
